// File: rtl/act_bit_place_encoder.sv
// Activation-to-bit-place encoder: takes one activation per handshake and emits
// one token per nonzero magnitude bit, MSB first, for the bit-serial PE array.
module act_bit_place_encoder #(
  parameter int DATA_W      = 8,
  parameter int PLACE_W     = $clog2(DATA_W),
  parameter int SIGNED_MODE = 0,
  parameter int MAX_PLACES  = DATA_W
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PLACE_W-1:0] out_place,
  output logic               out_sign,
  output logic               out_last,
  output logic               out_zero,
  output logic               out_trunc,
  output logic               busy
);

  // One spare bit so the token count never wraps for any legal MAX_PLACES.
  localparam int CNT_W = PLACE_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PLACES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t              state_q,    state_d;
  logic [DATA_W-1:0]   residual_q, residual_d;
  logic                sign_q,     sign_d;
  logic                zero_q,     zero_d;
  logic [CNT_W-1:0]    count_q,    count_d;

  logic                emit;
  logic                fire;
  logic                load;
  logic [PLACE_W-1:0]  place_c;
  logic [DATA_W-1:0]   top_bit;
  logic [DATA_W-1:0]   rest;
  logic                cap_hit;
  logic                last_c;
  logic                trunc_c;
  logic                in_neg;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    if ((SIGNED_MODE != 0) && v[DATA_W-1]) begin
      return ~v + 1'b1;
    end
    return v;
  endfunction

  function automatic logic [PLACE_W-1:0] top_index(input logic [DATA_W-1:0] v);
    logic [PLACE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) begin
        idx = PLACE_W'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    emit    = (state_q == S_EMIT);
    place_c = zero_q ? '0 : top_index(residual_q);
    top_bit = {{(DATA_W-1){1'b0}}, 1'b1} << place_c;
    rest    = residual_q & ~top_bit;
    cap_hit = (count_q == CNT_LAST);
    last_c  = zero_q || (rest == '0) || cap_hit;
    trunc_c = last_c && !zero_q && cap_hit && (rest != '0);
    fire    = emit && out_ready;
    in_neg  = (SIGNED_MODE != 0) && in_data[DATA_W-1];
  end

  // Outputs depend on registered state only; in_ready alone also sees out_ready
  // so the next value can load on the edge that retires the last token.
  always_comb begin
    out_valid = emit;
    out_place = emit ? place_c : '0;
    out_sign  = emit && sign_q;
    out_last  = emit && last_c;
    out_zero  = emit && zero_q;
    out_trunc = emit && trunc_c;
    busy      = emit;
    in_ready  = !emit || (fire && last_c);
    load      = in_valid && in_ready;
  end

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    count_d    = count_q;

    if (fire) begin
      if (last_c) begin
        state_d = S_IDLE;
      end else begin
        residual_d = rest;
        count_d    = count_q + 1'b1;
      end
    end

    if (load) begin
      state_d    = S_EMIT;
      residual_d = magnitude(in_data);
      sign_d     = in_neg;
      zero_d     = (magnitude(in_data) == '0);
      count_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      residual_q <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      count_q    <= count_d;
    end
  end

endmodule
